// File: rtl/dcache_pkg.sv
// Shared widths, FSM encoding and address helpers for the direct-mapped data cache.
package dcache_pkg;
  localparam int OFFSET_W = 5;
  localparam int INDEX_W  = 5;
  localparam int TAG_W    = 22;
  localparam int LINE_W   = 256;
  localparam int WORD_W   = 32;
  localparam int WSEL_W   = OFFSET_W - 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MISS,
    ST_WRITEBACK,
    ST_ALLOCATE
  } state_e;

  function automatic logic [31:0] line_addr(input logic [TAG_W-1:0]   tag,
                                            input logic [INDEX_W-1:0] idx);
    return {tag, idx, {OFFSET_W{1'b0}}};
  endfunction
endpackage

// File: rtl/dcache_controller_if.sv
// CPU-side and memory-side signals of the data cache; master is the cache controller.
interface dcache_controller_if;
  logic                        cpu_req_i;
  logic                        cpu_we_i;
  logic [31:0]                 cpu_addr_i;
  logic [31:0]                 cpu_data_i;
  logic [31:0]                 cpu_data_o;
  logic                        cpu_stall_o;
  logic                        mem_enable_o;
  logic                        mem_write_o;
  logic [31:0]                 mem_addr_o;
  logic [dcache_pkg::LINE_W-1:0] mem_data_o;
  logic [dcache_pkg::LINE_W-1:0] mem_data_i;
  logic                        mem_ack_i;

  modport master (
    input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_data_i, mem_data_i, mem_ack_i,
    output cpu_data_o, cpu_stall_o, mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
  );

  modport slave (
    output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_data_i, mem_data_i, mem_ack_i,
    input  cpu_data_o, cpu_stall_o, mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
  );
endinterface

// File: rtl/dcache_sram.sv
// Cache line storage: valid/dirty/tag/data per set, asynchronous read of one set,
// synchronous whole-line refill or single-word merge.
module dcache_sram
  import dcache_pkg::*;
#(
  parameter int NUM_SETS   = 32,
  parameter int LINE_BYTES = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [INDEX_W-1:0]        idx_i,
  output logic                      rd_valid_o,
  output logic                      rd_dirty_o,
  output logic [TAG_W-1:0]          rd_tag_o,
  output logic [LINE_BYTES*8-1:0]   rd_line_o,
  input  logic                      line_we_i,
  input  logic [TAG_W-1:0]          line_tag_i,
  input  logic [LINE_BYTES*8-1:0]   line_data_i,
  input  logic                      word_we_i,
  input  logic [WSEL_W-1:0]         word_sel_i,
  input  logic [WORD_W-1:0]         word_data_i
);
  logic [NUM_SETS-1:0]     valid_q, valid_d;
  logic [NUM_SETS-1:0]     dirty_q, dirty_d;
  logic [TAG_W-1:0]        tag_q  [NUM_SETS];
  logic [LINE_BYTES*8-1:0] data_q [NUM_SETS];

  assign rd_valid_o = valid_q[idx_i];
  assign rd_dirty_o = dirty_q[idx_i];
  assign rd_tag_o   = tag_q[idx_i];
  assign rd_line_o  = data_q[idx_i];

  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    if (line_we_i) begin
      valid_d[idx_i] = 1'b1;
      dirty_d[idx_i] = 1'b0;
    end
    if (word_we_i) begin
      dirty_d[idx_i] = 1'b1;
    end
  end

  // Only the status bits are cleared; stale tag/data are harmless once valid drops.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (line_we_i) begin
        tag_q[idx_i]  <= line_tag_i;
        data_q[idx_i] <= line_data_i;
      end else if (word_we_i) begin
        data_q[idx_i][{word_sel_i, {5{1'b0}}} +: WORD_W] <= word_data_i;
      end
    end
  end
endmodule

// File: rtl/dcache_controller.sv
// Write-back, write-allocate direct-mapped D-cache controller: hit decode, miss FSM,
// registered memory request outputs and pipeline stall generation.
module dcache_controller
  import dcache_pkg::*;
#(
  parameter int NUM_SETS   = 32,
  parameter int LINE_BYTES = 32
) (
  input logic                 clk_i,
  input logic                 rst_i,
  dcache_controller_if.master bus
);
  state_e              state_q, state_d;
  logic                mem_en_q, mem_en_d;
  logic                mem_wr_q, mem_wr_d;
  logic [31:0]         mem_addr_q, mem_addr_d;
  logic [LINE_W-1:0]   mem_data_q, mem_data_d;

  logic [TAG_W-1:0]    req_tag, rd_tag;
  logic [INDEX_W-1:0]  req_idx;
  logic [WSEL_W-1:0]   req_word;
  logic                rd_valid, rd_dirty, hit;
  logic                line_we, word_we;
  logic [LINE_W-1:0]   rd_line;
  logic                unused_addr_lsb;

  assign req_tag         = bus.cpu_addr_i[OFFSET_W+INDEX_W +: TAG_W];
  assign req_idx         = bus.cpu_addr_i[OFFSET_W +: INDEX_W];
  assign req_word        = bus.cpu_addr_i[2 +: WSEL_W];
  assign unused_addr_lsb = ^bus.cpu_addr_i[1:0];
  assign hit             = bus.cpu_req_i & rd_valid & (rd_tag == req_tag);

  dcache_sram #(
    .NUM_SETS   (NUM_SETS),
    .LINE_BYTES (LINE_BYTES)
  ) u_sram (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .idx_i       (req_idx),
    .rd_valid_o  (rd_valid),
    .rd_dirty_o  (rd_dirty),
    .rd_tag_o    (rd_tag),
    .rd_line_o   (rd_line),
    .line_we_i   (line_we),
    .line_tag_i  (req_tag),
    .line_data_i (bus.mem_data_i),
    .word_we_i   (word_we),
    .word_sel_i  (req_word),
    .word_data_i (bus.cpu_data_i)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      mem_en_q   <= 1'b0;
      mem_wr_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
    end else begin
      state_q    <= state_d;
      mem_en_q   <= mem_en_d;
      mem_wr_q   <= mem_wr_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (bus.cpu_req_i && !hit) state_d = ST_MISS;
      ST_MISS:      state_d = (rd_valid && rd_dirty) ? ST_WRITEBACK : ST_ALLOCATE;
      ST_WRITEBACK: if (bus.mem_ack_i) state_d = ST_ALLOCATE;
      ST_ALLOCATE:  if (bus.mem_ack_i) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // Memory request registers only move on FSM transitions, so the bus stays stable until ack.
  always_comb begin
    mem_en_d   = mem_en_q;
    mem_wr_d   = mem_wr_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    line_we    = 1'b0;
    word_we    = 1'b0;
    case (state_q)
      ST_IDLE: word_we = hit & bus.cpu_we_i;
      ST_MISS: begin
        mem_en_d = 1'b1;
        if (rd_valid && rd_dirty) begin
          mem_wr_d   = 1'b1;
          mem_addr_d = line_addr(rd_tag, req_idx);
          mem_data_d = rd_line;
        end else begin
          mem_wr_d   = 1'b0;
          mem_addr_d = line_addr(req_tag, req_idx);
        end
      end
      ST_WRITEBACK: begin
        if (bus.mem_ack_i) begin
          mem_en_d   = 1'b1;
          mem_wr_d   = 1'b0;
          mem_addr_d = line_addr(req_tag, req_idx);
        end
      end
      ST_ALLOCATE: begin
        if (bus.mem_ack_i) begin
          mem_en_d = 1'b0;
          line_we  = 1'b1;
        end
      end
      default: ;
    endcase
    bus.cpu_stall_o = (state_q != ST_IDLE) | (bus.cpu_req_i & ~hit);
    bus.cpu_data_o  = hit ? rd_line[{req_word, {5{1'b0}}} +: WORD_W] : '0;
  end

  assign bus.mem_enable_o = mem_en_q;
  assign bus.mem_write_o  = mem_wr_q;
  assign bus.mem_addr_o   = mem_addr_q;
  assign bus.mem_data_o   = mem_data_q;
endmodule

// File: tb/tb_dcache_controller.sv
// Random and directed load/store traffic against a word-level memory model and
// a tag-only cache model that predicts stalls and memory traffic.
module tb_dcache_controller;
  logic clk;
  logic rst;

  dcache_controller_if bus ();

  dcache_controller #(
    .NUM_SETS   (32),
    .LINE_BYTES (32)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    bit           w;
    bit [31:0]    a;
    logic [255:0] d;
  } req_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  bit          stuck    = 0;
  int          n_lat    = 4;
  bit          resp_on  = 1;
  int          force_req = 0;
  int          en_cycles = 0;
  req_t        log_q[$];

  bit [31:0]   arch [bit [31:0]];
  bit [31:0]   dram [bit [31:0]];
  bit          m_valid [32];
  bit          m_dirty [32];
  bit [21:0]   m_tag   [32];

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit [31:0] pattern(input bit [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic bit [31:0] arch_rd(input bit [31:0] a);
    return arch.exists(a) ? arch[a] : pattern(a);
  endfunction

  function automatic bit [31:0] dram_rd(input bit [31:0] a);
    return dram.exists(a) ? dram[a] : pattern(a);
  endfunction

  function automatic logic [255:0] arch_line(input bit [31:0] la);
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = arch_rd(la + 32'(4*w));
    return l;
  endfunction

  function automatic logic [255:0] dram_line(input bit [31:0] la);
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = dram_rd(la + 32'(4*w));
    return l;
  endfunction

  // Off-chip memory: acks the Nth enabled cycle of each request, logs every transfer.
  initial begin
    int           cnt;
    bit           ack_fired;
    int           force_done;
    bit           hold_w;
    bit [31:0]    hold_a;
    logic [255:0] hold_d;
    cnt = 0; ack_fired = 0; force_done = 0;
    hold_w = 0; hold_a = '0; hold_d = '0;
    bus.mem_ack_i  = 1'b0;
    bus.mem_data_i = '0;
    forever begin
      @(negedge clk);
      bus.mem_ack_i = 1'b0;
      if (ack_fired) begin
        cnt = 0;
        ack_fired = 0;
      end
      if (force_req != force_done) begin
        force_done     = force_req;
        bus.mem_data_i = {8{32'hBADC_0FFE}};
        bus.mem_ack_i  = 1'b1;
      end else if (bus.mem_enable_o && resp_on) begin
        en_cycles++;
        if (cnt == 0) begin
          hold_w = bus.mem_write_o;
          hold_a = bus.mem_addr_o;
          hold_d = bus.mem_data_o;
        end else begin
          check("mem_req_hold", 256'({bus.mem_write_o, bus.mem_addr_o}), 256'({hold_w, hold_a}));
          if (hold_w) check("mem_wdata_hold", bus.mem_data_o, hold_d);
        end
        cnt++;
        if (cnt == n_lat) begin
          log_q.push_back('{w: hold_w, a: hold_a, d: hold_d});
          if (hold_w) begin
            for (int w = 0; w < 8; w++) dram[hold_a + 32'(4*w)] = hold_d[w*32 +: 32];
          end else begin
            bus.mem_data_i = dram_line(hold_a);
          end
          bus.mem_ack_i = 1'b1;
          ack_fired = 1;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_valid[i] = 0;
      m_dirty[i] = 0;
      m_tag[i]   = '0;
    end
    arch = dram;
  endtask

  task automatic do_access(input bit we, input bit [31:0] addr, input bit [31:0] wd, input int n);
    int           idx;
    bit [21:0]    tag;
    bit [31:0]    la, va;
    bit           hit, dirty_v, done;
    logic [255:0] vline;
    int           exp_stall, exp_en, exp_reqs, stalls, en0, log0;
    if (stuck) return;
    idx       = int'(addr[9:5]);
    tag       = addr[31:10];
    la        = {addr[31:5], 5'b0};
    hit       = m_valid[idx] && (m_tag[idx] == tag);
    dirty_v   = !hit && m_valid[idx] && m_dirty[idx];
    va        = {m_tag[idx], addr[9:5], 5'b0};
    vline     = arch_line(va);
    exp_stall = hit ? 0 : (dirty_v ? 2*n + 2 : n + 2);
    exp_en    = hit ? 0 : (dirty_v ? 2*n : n);
    exp_reqs  = hit ? 0 : (dirty_v ? 2 : 1);
    stalls    = 0;
    done      = 0;
    n_lat     = n;
    en0       = en_cycles;
    log0      = log_q.size();
    bus.cpu_req_i  = 1'b1;
    bus.cpu_we_i   = we;
    bus.cpu_addr_i = addr;
    bus.cpu_data_i = wd;
    for (int c = 0; c < 4*n + 16 && !done; c++) begin
      @(negedge clk);
      if (bus.cpu_stall_o) stalls++;
      else done = 1;
    end
    check("stall_released", 256'(done), 256'(1));
    if (!done) stuck = 1;
    if (done && !we) check("load_data", 256'(bus.cpu_data_o), 256'(arch_rd(addr)));
    check("stall_cycles", 256'(stalls), 256'(exp_stall));
    @(posedge clk);
    #1;
    bus.cpu_req_i = 1'b0;
    bus.cpu_we_i  = 1'b0;
    check("mem_enable_cycles", 256'(en_cycles - en0), 256'(exp_en));
    check("mem_transfers", 256'(log_q.size() - log0), 256'(exp_reqs));
    if (dirty_v && log_q.size() - log0 == 2) begin
      check("wb_req", 256'({log_q[log0].w, log_q[log0].a}), 256'({1'b1, va}));
      check("wb_line", log_q[log0].d, vline);
      check("refill_req", 256'({log_q[log0+1].w, log_q[log0+1].a}), 256'({1'b0, la}));
    end else if (!hit && !dirty_v && log_q.size() - log0 == 1) begin
      check("refill_req", 256'({log_q[log0].w, log_q[log0].a}), 256'({1'b0, la}));
    end
    if (!hit) begin
      m_valid[idx] = 1;
      m_dirty[idx] = 0;
      m_tag[idx]   = tag;
    end
    if (we) begin
      m_dirty[idx] = 1;
      arch[addr]   = wd;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    rst            = 1'b1;
    bus.cpu_req_i  = 1'b0;
    bus.cpu_we_i   = 1'b0;
    bus.cpu_addr_i = '0;
    bus.cpu_data_i = '0;
    dram[32'h44]   = 32'h1111_1111;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_mem_ctrl", 256'({bus.mem_enable_o, bus.mem_write_o, bus.mem_addr_o}), 256'(0));
    check("rst_mem_data", bus.mem_data_o, 256'(0));
    check("rst_stall_data", 256'({bus.cpu_stall_o, bus.cpu_data_o}), 256'(0));
    @(posedge clk);
    #1;

    do_access(0, 32'h0000_0040, 32'h0, 4);
    do_access(0, 32'h0000_0044, 32'h0, 4);
    do_access(1, 32'h0000_0044, 32'hDEAD_BEEF, 4);
    do_access(0, 32'h0000_0044, 32'h0, 4);
    do_access(0, 32'h0000_0440, 32'h0, 4);
    check("wb_word1_to_dram", 256'(dram_rd(32'h44)), 256'(32'hDEAD_BEEF));

    force_req++;
    @(negedge clk);
    @(negedge clk);
    check("idle_ack_ignored", 256'({bus.cpu_stall_o, bus.mem_enable_o}), 256'(0));
    @(posedge clk);
    #1;
    do_access(0, 32'h0000_0444, 32'h0, 4);

    // Reset while a refill is outstanding.
    n_lat          = 50;
    bus.cpu_req_i  = 1'b1;
    bus.cpu_addr_i = 32'h0000_0840;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      seen = bus.mem_enable_o && !bus.mem_write_o;
    end
    check("alloc_reached", 256'(seen), 256'(1));
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.cpu_req_i = 1'b0;
    resp_on = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    @(negedge clk);
    check("midmiss_rst_ctrl", 256'({bus.mem_enable_o, bus.mem_write_o, bus.mem_addr_o}), 256'(0));
    check("midmiss_rst_data", bus.mem_data_o, 256'(0));
    check("midmiss_rst_stall", 256'(bus.cpu_stall_o), 256'(0));
    force_req++;
    @(negedge clk);
    @(negedge clk);
    check("late_ack_ignored", 256'({bus.cpu_stall_o, bus.mem_enable_o}), 256'(0));
    resp_on = 1;
    @(posedge clk);
    #1;
    do_access(0, 32'h0000_0040, 32'h0, 3);
    do_access(0, 32'h0000_0044, 32'h0, 3);

    for (int i = 0; i < 300; i++) begin
      bit [31:0] a;
      a = ($urandom_range(0, 3) << 10) | ($urandom_range(0, 7) << 5) | ($urandom_range(0, 7) << 2);
      do_access(bit'($urandom_range(0, 1)), a, $urandom, int'($urandom_range(1, 5)));
    end

    @(negedge clk);
    check("idle_outputs", 256'({bus.cpu_stall_o, bus.cpu_data_o}), 256'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/dcache_controller.md
# dcache_controller

Direct-mapped, write-back, write-allocate data-cache controller between the MEM stage and off-chip data memory. Decodes each load/store from the EX/MEM pipeline register into hit or miss, serves hits in the same cycle, and on a miss sequences an optional dirty-line write-back followed by a line refill. While the miss is outstanding it drives `cpu_stall_o`, which feeds the `Mem_Stall_i` input of every pipeline register and freezes the whole pipeline.

## Interface
- `NUM_SETS`, 32: lines in the cache; power of two.
- `LINE_BYTES`, 32: bytes per line (256-bit line, 8 words).
- `clk_i` in 1: clock, all state updates on rising edge.
- `rst_i` in 1: reset, synchronous, active-high.
- `cpu_req_i` in 1: access valid (MemRead | MemWrite from EX/MEM).
- `cpu_we_i` in 1: 1 = store word, 0 = load word.
- `cpu_addr_i` in 32: byte address (ALU result), word-aligned.
- `cpu_data_i` in 32: store data.
- `cpu_data_o` out 32: load data; valid when hit.
- `cpu_stall_o` out 1: pipeline stall (to all `Mem_Stall_i`).
- `mem_enable_o` out 1: memory request valid.
- `mem_write_o` out 1: 1 = line write-back, 0 = line read.
- `mem_addr_o` out 32: line-aligned address, low 5 bits zero.
- `mem_data_o` out 256: write-back line data.
- `mem_data_i` in 256: refill line data, valid with `mem_ack_i`.
- `mem_ack_i` in 1: one-cycle completion pulse from memory.

## Operation
- Address split: offset = addr[4:0] (word select = addr[4:2]), index = addr[9:5], tag = addr[31:10] (22 bits).
- Per-set state: valid, dirty, tag, 256-bit data. Hit = req & valid[index] & (tag match).
- States: IDLE, MISS, WRITEBACK, ALLOCATE.
- IDLE: hit → load returns word combinationally; store writes word `addr[4:2]` of line and sets dirty at the edge; no stall. Miss → stall, go to MISS.
- MISS: if victim valid & dirty → WRITEBACK and register `mem_enable_o`=1, `mem_write_o`=1, `mem_addr_o`={victim tag, index, 5'b0}, `mem_data_o`=victim line. Otherwise → ALLOCATE and register enable=1, write=0, addr={req tag, index, 5'b0}.
- WRITEBACK: hold all mem outputs stable until `mem_ack_i`; on ack → ALLOCATE with enable kept high, write=0, addr=refill address (new request begins the cycle after ack).
- ALLOCATE: hold until `mem_ack_i`; on ack write `mem_data_i` into line, tag=req tag, valid=1, dirty=0, deassert enable, → IDLE. Access then replays in IDLE as a hit (store merges then, setting dirty).
- `cpu_stall_o` = (state≠IDLE) | (req & ~hit). Requester holds req/addr/data stable while stalled (guaranteed by frozen EX/MEM).
- `mem_ack_i` outside WRITEBACK/ALLOCATE is ignored.
- `cpu_data_o` = 0 when not hit.

## Timing
- Reset values: state IDLE, all valid and dirty bits 0, `mem_enable_o`=0, `mem_write_o`=0, `mem_addr_o`=0, `mem_data_o`=0; `cpu_stall_o`=0 and `cpu_data_o`=0 while `cpu_req_i`=0.
- Hit latency 0 cycles (combinational data, no stall).
- Memory ack arrives in the Nth cycle of an enabled request (N ≥ 1). Clean miss stall: N+2 cycles. Dirty miss stall: 2N+2 cycles.
- Mem outputs are registered, change only on state transitions.
- Reset mid-miss: next edge returns to IDLE, enable drops, all lines invalidated; dirty data is discarded; in-flight ack afterwards ignored.
- Reset has priority over any simultaneous ack or request.

## Structure
- Package `dcache_pkg`: OFFSET_W=5, INDEX_W=5, TAG_W=22, LINE_W=256, state enum.
- Sub-module `dcache_sram`: valid/dirty/tag/data arrays, async read, sync write with word-merge enable and synchronous clear of valid/dirty on reset.
- Controller holds FSM, hit compare, mem-output registers, stall logic.

## Test plan
- Reset, lw 0x0000_0040, memory N=4 acks line with word1=0x1111_1111 → one read at mem_addr 0x40, stall high exactly 6 cycles, then `cpu_data_o`=0x1111_1111.
- lw 0x44 right after → hit, stall 0, data 0x1111_1111, no `mem_enable_o`.
- sw 0xDEAD_BEEF to 0x44 → no memory traffic; following lw 0x44 returns 0xDEAD_BEEF.
- lw 0x440 (same index 2, different tag), N=4 → write-back at 0x40 with word1=0xDEAD_BEEF, then read at 0x440; stall exactly 10 cycles.
- Assert `rst_i` during ALLOCATE → enable low after edge, state IDLE; next lw 0x40 misses again.
- Pulse `mem_ack_i` while IDLE with no request → no state change, no array update.
